r_route_ctrl: RTL
=================

# r_route_ctrl

Read-response routing controller for one slave port of the AXI interconnect. It records the issuing master of every read address accepted by the slave in an in-order FIFO. It drives the select and gated valid into the downstream R-channel demux, and returns the selected master's ready to the slave. Each entry retires on the last beat of its burst. Ordering is strictly in-order per slave; IDs are not used for routing.

## Interface
- N_MASTERS, 6, number of master ports served by the demux
- SEL_W, 3, width of master index / demux select
- DEPTH, 8, maximum outstanding read bursts (power of 2, ≥2)
- BEAT_W, 8, width of beat counter (AXI4 max burst 256)

- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- ar_push  in  1  AR handshake completed at this slave (ARVALID&ARREADY)
- ar_master  in  SEL_W  index of master that issued the AR, valid with ar_push
- ar_ready_gate  out  1  high when FIFO not full; ANDed into slave ARREADY
- r_valid  in  1  RVALID from slave
- r_last  in  1  RLAST from slave
- r_ready_m  in  N_MASTERS  RREADY from each master
- r_valid_o  out  1  gated RVALID to demux
- r_ready_s  out  1  RREADY to slave
- sel  out  SEL_W  demux select = head master index
- outstanding  out  $clog2(DEPTH)+1  bursts in flight
- beat_cnt  out  BEAT_W  beats transferred in current burst
- err_orphan  out  1  sticky: R beat seen with no outstanding burst

## Operation
- FIFO of SEL_W-bit master indices; count, wr_ptr, rd_ptr registers; pointers wrap modulo DEPTH.
- full = (count==DEPTH); empty = (count==0); ar_ready_gate = !full.
- Push: ar_push & !full writes ar_master at wr_ptr. ar_push while full is ignored, state unchanged.
- ar_master ≥ N_MASTERS: pushed as-is; r_ready_s uses r_ready_m bit only if index < N_MASTERS, else 0.
- sel = FIFO head when !empty, else 0.
- r_valid_o = r_valid & !empty.
- r_ready_s = !empty & r_ready_m[sel].
- Beat handshake = r_valid & r_ready_s. On beat: beat_cnt+1 (wraps at 2^BEAT_W); if r_last, beat_cnt←0 and pop head.
- Simultaneous push and pop: both occur, count unchanged, head advances.
- Push into empty FIFO with r_valid already high: beat is not accepted that cycle; accepted from the next cycle.
- outstanding = count.

## Timing
- Reset values: count 0, pointers 0, beat_cnt 0, err_orphan 0. Resulting outputs: sel 0, r_valid_o 0, r_ready_s 0, ar_ready_gate 1, outstanding 0.
- rst mid-burst: all state cleared next edge; in-flight entries discarded; no pop or beat counted in the reset cycle.
- Push to sel/r_valid_o visibility: 1 cycle.
- r_valid_o, r_ready_s, sel are combinational from registered head/count and the current r_valid/r_ready_m. There is no added latency on the data path.
- Pop on last beat: next head is valid on sel the following cycle. Back-to-back bursts to different masters therefore incur zero bubble.
- ar_ready_gate deasserts in the cycle count reaches DEPTH. A pop in that same cycle does not reopen it until the next cycle.

## Configuration
- R_ROUTE_ORPHAN_CHK_EN defined: r_valid while empty sets err_orphan (sticky until rst). In that state r_ready_s is forced 1 to drain and drop orphan beats. beat_cnt is unaffected.
- Not defined: err_orphan tied 0. Orphan r_valid is stalled: r_ready_s = 0, r_valid_o = 0.

## Structure
- Shared package axi_ic_pkg: N_MASTERS, SEL_W, master index constants M00..M05 (0..5), matching the demux select encoding.
- One sub-module: idx_fifo (parameterised DEPTH×SEL_W synchronous FIFO with push/pop/full/empty/count). Beat counter and ready/valid gating live in r_route_ctrl.

## Test plan
- Reset: assert rst with r_valid=1 and ar_push=1. Required: sel=0, r_valid_o=0, r_ready_s=0, ar_ready_gate=1, outstanding=0 after release.
- Single burst: push master 3, then 4 beats with r_ready_m=6'b001000, r_last on beat 4. Required: sel=3 from cycle+1, beat_cnt 1..3 then 0, outstanding 1→0.
- Back-to-back: push 1, 5, 0. Stream 2-beat bursts with all ready. Required: sel sequence 1,5,0 with no idle cycle between bursts; r_ready_s follows only r_ready_m[sel].
- Full: push 8 entries with no R traffic. Required: ar_ready_gate=0, a 9th ar_push is ignored (outstanding stays 8). Pop one, then ar_ready_gate=1 the next cycle.
- Simultaneous push+pop at count 4: required count stays 4, head advances, new entry is at tail.
- Orphan r_valid with FIFO empty. Macro defined: r_ready_s=1, err_orphan=1 (sticky). Macro undefined: r_ready_s=0, err_orphan=0.

Source files
------------

// File: rtl/axi_ic_pkg.sv
// Shared interconnect constants: master count, select width and demux select encoding.
package axi_ic_pkg;

  localparam int unsigned N_MASTERS = 6;
  localparam int unsigned SEL_W     = 3;

  localparam logic [SEL_W-1:0] M00 = 3'd0;
  localparam logic [SEL_W-1:0] M01 = 3'd1;
  localparam logic [SEL_W-1:0] M02 = 3'd2;
  localparam logic [SEL_W-1:0] M03 = 3'd3;
  localparam logic [SEL_W-1:0] M04 = 3'd4;
  localparam logic [SEL_W-1:0] M05 = 3'd5;

endpackage

// File: rtl/idx_fifo.sv
// Synchronous DEPTH x WIDTH FIFO of master indices; head is read combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module idx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PtrW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read once count marks them valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/r_route_ctrl.sv
// In-order read-response router for one slave port; retires a burst on its last beat.
// Optional R_ROUTE_ORPHAN_CHK_EN: flag and drain R beats arriving with nothing outstanding.
module r_route_ctrl
  import axi_ic_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned BEAT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ar_push,
  input  logic [SEL_W-1:0]       ar_master,
  output logic                   ar_ready_gate,
  input  logic                   r_valid,
  input  logic                   r_last,
  input  logic [N_MASTERS-1:0]   r_ready_m,
  output logic                   r_valid_o,
  output logic                   r_ready_s,
  output logic [SEL_W-1:0]       sel,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic [BEAT_W-1:0]      beat_cnt,
  output logic                   err_orphan
);

  logic [SEL_W-1:0]  head;
  logic              full, empty;
  logic              beat, pop;
  logic              master_ready;
  logic [BEAT_W-1:0] beat_cnt_d, beat_cnt_q;

  idx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SEL_W)
  ) u_idx_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (ar_push),
    .data_i  (ar_master),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding)
  );

  assign ar_ready_gate = ~full;
  assign sel           = empty ? '0 : head;
  assign r_valid_o     = r_valid & ~empty;

  // Out-of-range indices match no bit and therefore never see a ready.
  always_comb begin
    master_ready = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (sel == SEL_W'(i)) master_ready = r_ready_m[i];
    end
  end

`ifdef R_ROUTE_ORPHAN_CHK_EN
  logic err_orphan_d, err_orphan_q;

  assign r_ready_s    = empty ? r_valid : master_ready;
  assign err_orphan_d = err_orphan_q | (r_valid & empty);
  assign err_orphan   = err_orphan_q;

  always_ff @(posedge clk) begin
    if (rst) err_orphan_q <= 1'b0;
    else     err_orphan_q <= err_orphan_d;
  end
`else
  assign r_ready_s  = ~empty & master_ready;
  assign err_orphan = 1'b0;
`endif

  // Dropped orphan beats are not part of any burst, so they neither count nor pop.
  assign beat = r_valid & r_ready_s & ~empty;
  assign pop  = beat & r_last;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (beat) beat_cnt_d = r_last ? '0 : beat_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) beat_cnt_q <= '0;
    else     beat_cnt_q <= beat_cnt_d;
  end

  assign beat_cnt = beat_cnt_q;

endmodule
